dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 151 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported word RAM.
// Sub-word stores are done as read-modify-write through a word buffer.
module dmem_arbiter #(
  parameter int XLEN      = 32,
  parameter int NUM_PORTS = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_PORTS-1:0]                 req_valid,
  output logic [NUM_PORTS-1:0]                 req_ready,
  input  logic [NUM_PORTS-1:0]                 req_write,
  input  logic [NUM_PORTS-1:0][XLEN-1:0]       req_addr,
  input  logic [NUM_PORTS-1:0][XLEN-1:0]       req_wdata,
  input  logic [NUM_PORTS-1:0][XLEN/8-1:0]     req_wstrb,
  output logic [NUM_PORTS-1:0]                 resp_valid,
  output logic [XLEN-1:0]                      resp_rdata,
  output logic                                 ram_write_enable,
  output logic [XLEN-1:0]                      ram_address,
  output logic [XLEN-1:0]                      ram_write_data,
  input  logic [XLEN-1:0]                      ram_read_data
);

  localparam int SW = XLEN / 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]      state_q, state_d;
  logic            last_q, last_d;
  logic            port_q, port_d;
  logic            write_q, write_d;
  logic [XLEN-3:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [SW-1:0]   wstrb_q, wstrb_d;
  logic [XLEN-1:0] buf_q, buf_d;

  logic [1:0]      gnt;
  logic            hs;
  logic            sel;
  logic [XLEN-1:0] merged;
  logic            unused_addr;

  // Byte offset is irrelevant to a word RAM.
  assign unused_addr = ^{req_addr[0][1:0], req_addr[1][1:0]};

  // With both ports contending, the one not granted last wins.
  always_comb begin
    gnt = 2'b00;
    unique case (1'b1)
      (req_valid == 2'b11): gnt = last_q ? 2'b01 : 2'b10;
      (req_valid == 2'b01): gnt = 2'b01;
      (req_valid == 2'b10): gnt = 2'b10;
      default:              gnt = 2'b00;
    endcase
  end

  assign req_ready = (state_q == S_IDLE && !reset) ? gnt : 2'b00;
  assign hs        = |(req_valid & req_ready);
  assign sel       = req_ready[1];

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    port_d  = port_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    buf_d   = buf_q;
    unique case (state_q)
      S_IDLE: begin
        if (hs) begin
          port_d  = sel;
          last_d  = sel;
          write_d = req_write[sel];
          addr_d  = req_addr[sel][XLEN-1:2];
          wdata_d = req_wdata[sel];
          wstrb_d = req_wstrb[sel];
          if (req_write[sel] && (&req_wstrb[sel]))
            state_d = S_WRITE;
          else
            state_d = S_READ;
        end
      end
      S_READ: begin
        buf_d = ram_read_data;
        if (write_q && (|wstrb_q))
          state_d = S_WRITE;
        else
          state_d = S_RESP;
      end
      S_WRITE: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      port_q  <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      port_q  <= port_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      buf_q   <= buf_d;
    end
  end

  for (genvar k = 0; k < SW; k++) begin : g_lane
    assign merged[8*k +: 8] =
      wstrb_q[k] ? wdata_q[8*k +: 8] : buf_q[8*k +: 8];
  end

  // Outputs are gated by reset so a WRITE cycle cut by reset never commits.
  always_comb begin
    ram_write_enable = 1'b0;
    ram_address      = '0;
    ram_write_data   = '0;
    resp_valid       = 2'b00;
    resp_rdata       = '0;
    if (!reset) begin
      unique case (state_q)
        S_READ: ram_address = {addr_q, 2'b00};
        S_WRITE: begin
          ram_address      = {addr_q, 2'b00};
          ram_write_enable = 1'b1;
          ram_write_data   = merged;
        end
        S_RESP: begin
          resp_valid = port_q ? 2'b10 : 2'b01;
          resp_rdata = write_q ? '0 : buf_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: word RAM model, latency-schedule reference
// model with per-cycle compare, directed cases and random traffic.
module tb_dmem_arbiter;

  logic             clk;
  logic             reset;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0]       req_write;
  logic [1:0][31:0] req_addr;
  logic [1:0][31:0] req_wdata;
  logic [1:0][3:0]  req_wstrb;
  logic [1:0]       resp_valid;
  logic [31:0]      resp_rdata;
  logic             ram_write_enable;
  logic [31:0]      ram_address;
  logic [31:0]      ram_write_data;
  logic [31:0]      ram_read_data;

  dmem_arbiter #(.XLEN(32), .NUM_PORTS(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .ram_write_enable(ram_write_enable),
    .ram_address(ram_address),
    .ram_write_data(ram_write_data),
    .ram_read_data(ram_read_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model (64 words) with a preload port.
  logic [31:0] mem [0:63];
  logic        poke_en = 1'b0;
  logic [5:0]  poke_idx = '0;
  logic [31:0] poke_val = '0;
  assign ram_read_data = mem[ram_address[7:2]];
  always @(posedge clk) begin
    if (ram_write_enable) mem[ram_address[7:2]] <= ram_write_data;
    else if (poke_en) mem[poke_idx] <= poke_val;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    failures++;
    $display("FAIL %s cyc=%0d bound expired", nm, cyc);
  endtask

  // Reference model: each accepted request expands into the list of
  // per-cycle outputs its latency class prescribes.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  rv;
    logic [31:0] rdata;
  } exp_t;

  exp_t        q[$];
  logic [31:0] gold [0:63];
  int          last_m = 1;

  initial begin : cmp
    exp_t e;
    logic [1:0] er;
    logic [31:0] old, mg, wa;
    int p;
    forever begin
      @(negedge clk);
      if (reset) begin
        q.delete();
        last_m = 1;
        chk("rst_ready", {30'd0, req_ready}, 32'd0);
        chk("rst_rvalid", {30'd0, resp_valid}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_we", {31'd0, ram_write_enable}, 32'd0);
        chk("rst_addr", ram_address, 32'd0);
        chk("rst_wdata", ram_write_data, 32'd0);
      end else begin
        if (poke_en) gold[poke_idx] = poke_val;
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("busy_ready", {30'd0, req_ready}, 32'd0);
          chk("rvalid", {30'd0, resp_valid}, {30'd0, e.rv});
          if (e.rv != 2'b00) chk("rdata", resp_rdata, e.rdata);
          chk("we", {31'd0, ram_write_enable}, {31'd0, e.we});
          chk("ram_addr", ram_address, e.addr);
          if (e.we) begin
            chk("ram_wdata", ram_write_data, e.wdata);
            gold[e.addr[7:2]] = e.wdata;
          end
        end else begin
          if (req_valid == 2'b11) er = (last_m == 1) ? 2'b01 : 2'b10;
          else er = req_valid;
          chk("idle_ready", {30'd0, req_ready}, {30'd0, er});
          chk("idle_rvalid", {30'd0, resp_valid}, 32'd0);
          chk("idle_we", {31'd0, ram_write_enable}, 32'd0);
          chk("idle_addr", ram_address, 32'd0);
          if (er != 2'b00) begin
            p = er[1] ? 1 : 0;
            last_m = p;
            wa = {req_addr[p][31:2], 2'b00};
            old = gold[req_addr[p][7:2]];
            for (int k = 0; k < 4; k++)
              mg[8*k +: 8] = req_wstrb[p][k] ?
                req_wdata[p][8*k +: 8] : old[8*k +: 8];
            if (req_write[p] && req_wstrb[p] == 4'hF) begin
              q.push_back('{1'b1, wa, req_wdata[p], 2'b00, 32'd0});
              q.push_back('{1'b0, 32'd0, 32'd0, er, 32'd0});
            end else if (req_write[p] && req_wstrb[p] != 4'h0) begin
              q.push_back('{1'b0, wa, 32'd0, 2'b00, 32'd0});
              q.push_back('{1'b1, wa, mg, 2'b00, 32'd0});
              q.push_back('{1'b0, 32'd0, 32'd0, er, 32'd0});
            end else begin
              q.push_back('{1'b0, wa, 32'd0, 2'b00, 32'd0});
              q.push_back('{1'b0, 32'd0, 32'd0, er,
                            req_write[p] ? 32'd0 : old});
            end
          end
        end
      end
    end
  end

  task automatic poke(input int idx, input logic [31:0] v);
    @(posedge clk); #1;
    poke_en = 1'b1;
    poke_idx = 6'(idx);
    poke_val = v;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  task automatic drive(input int p, input logic w, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] st);
    req_write[p] = w;
    req_addr[p]  = a;
    req_wdata[p] = wd;
    req_wstrb[p] = st;
    req_valid[p] = 1'b1;
  endtask

  task automatic issue(input int p, input logic w, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] st,
                       output int lat, output logic [31:0] rd);
    int n, hsc;
    bit got;
    lat = -1;
    rd = '0;
    @(posedge clk); #1;
    drive(p, w, a, wd, st);
    hsc = -1;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (req_ready[p]) begin
        hsc = cyc;
        break;
      end
      n++;
    end
    @(posedge clk); #1;
    req_valid[p] = 1'b0;
    if (hsc < 0) begin
      fail("hs_timeout");
      return;
    end
    got = 0;
    n = 0;
    while (n < 10) begin
      @(negedge clk);
      if (resp_valid[p]) begin
        got = 1;
        break;
      end
      n++;
    end
    if (!got) begin
      fail("resp_timeout");
      return;
    end
    lat = cyc - hsc;
    rd = resp_rdata;
  endtask

  // Handshake then reset in the following cycle (READ or WRITE).
  task automatic abort(input int p, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] st);
    int n;
    @(posedge clk); #1;
    drive(p, 1'b1, a, wd, st);
    n = 0;
    while (n < 20 && !req_ready[p]) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[p]) fail("abort_hs");
    @(posedge clk); #1;
    req_valid[p] = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int lat;
    logic [31:0] rd;
    logic [1:0] hs;
    int g[$];
    int n, r;
    reset = 1'b1;
    req_valid = '0;
    req_write = '0;
    req_addr = '0;
    req_wdata = '0;
    req_wstrb = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(posedge clk); #1;
    poke_en = 1'b1;
    for (int i = 0; i < 64; i++) begin
      poke_idx = 6'(i);
      poke_val = $urandom;
      @(posedge clk); #1;
    end
    poke_en = 1'b0;

    // Both ports contend continuously from reset.
    reset = 1'b1;
    drive(0, 1'b0, 32'h40, 32'd0, 4'h0);
    drive(1, 1'b0, 32'h44, 32'd0, 4'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    n = 0;
    while (g.size() < 4 && n < 40) begin
      @(negedge clk);
      n++;
      hs = req_valid & req_ready;
      if (hs[0]) g.push_back(0);
      if (hs[1]) g.push_back(1);
      if (hs != 2'b00) begin
        @(posedge clk); #1;
        req_addr[hs[1] ? 1 : 0] = 32'($urandom_range(0, 255));
      end
    end
    @(posedge clk); #1;
    req_valid = '0;
    chk("tie_count", 32'(g.size()), 32'd4);
    for (int i = 0; i < g.size(); i++)
      chk("tie_order", 32'(g[i]), 32'(i % 2));
    repeat (5) @(posedge clk);

    poke(4, 32'hDEADBEEF);
    issue(0, 1'b0, 32'h12, 32'd0, 4'h0, lat, rd);
    chk("load_lat", 32'(lat), 32'd2);
    chk("load_data", rd, 32'hDEADBEEF);

    poke(8, 32'h11223344);
    issue(1, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, lat, rd);
    chk("pstore_lat", 32'(lat), 32'd3);
    chk("pstore_mem", mem[8], 32'h11BB33DD);

    issue(0, 1'b1, 32'h30, 32'hCAFEF00D, 4'hF, lat, rd);
    chk("fstore_lat", 32'(lat), 32'd2);
    issue(0, 1'b0, 32'h33, 32'd0, 4'h0, lat, rd);
    chk("fstore_rb", rd, 32'hCAFEF00D);

    issue(1, 1'b1, 32'h20, 32'h12345678, 4'h0, lat, rd);
    chk("zstore_lat", 32'(lat), 32'd2);
    chk("zstore_mem", mem[8], 32'h11BB33DD);

    abort(0, 32'h20, 32'hFFFFFFFF, 4'b0011);
    chk("abort_read_mem", mem[8], 32'h11BB33DD);
    abort(1, 32'h20, 32'h00000000, 4'hF);
    chk("abort_write_mem", mem[8], 32'h11BB33DD);

    hs = '0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk); #1;
      reset = ($urandom_range(0, 59) == 0);
      for (int p = 0; p < 2; p++) begin
        if (hs[p]) req_valid[p] = 1'b0;
        if (!req_valid[p] && $urandom_range(0, 2) != 0) begin
          r = $urandom_range(0, 3);
          drive(p, 1'($urandom_range(0, 1)),
                32'($urandom_range(0, 255)), $urandom,
                (r == 0) ? 4'hF : (r == 1) ? 4'h0 :
                4'($urandom_range(0, 15)));
        end
      end
    end
    @(posedge clk); #1;
    reset = 1'b0;
    req_valid = '0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 64; i++) chk("final_mem", mem[i], gold[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
